// File: rtl/objective_pkg.sv
// objective_pkg: widths and error type shared by the activation stage and its objective.
package objective_pkg;
    localparam int ACT_W = 8;
    localparam int ERR_W = 16;
    typedef logic signed [ERR_W-1:0] err_t;
endpackage

// File: rtl/objective_stream_hold.sv
// stream_hold: one-entry holding register; ready is the inverse of the full flag, cleared on join.
module stream_hold #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    input  logic         clear,
    output logic         full,
    output logic [W-1:0] data
);
    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;
    logic         acc;

    always_comb begin
        acc    = in_valid && !full_q;
        full_d = clear ? 1'b0 : (acc ? 1'b1 : full_q);
        data_d = acc ? in_data : data_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign in_ready = !full_q;
    assign full     = full_q;
    assign data     = data_q;
endmodule

// File: rtl/objective.sv
// objective: joins result and target streams, emits signed error target-result, counts samples/mismatches.
module objective
    import objective_pkg::*;
#(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   train,
    input  logic                   result_valid,
    input  logic [ACT_W-1:0]       result_data,
    output logic                   result_ready,
    input  logic                   target_valid,
    input  logic [ACT_W-1:0]       target_data,
    output logic                   target_ready,
    output logic                   error_valid,
    output logic [ERR_W-1:0]       error_data,
    input  logic                   error_ready,
    output logic [COUNT_WIDTH-1:0] sample_count,
    output logic [COUNT_WIDTH-1:0] mismatch_count
);
    logic                   r_full, t_full, join_now;
    logic [ACT_W-1:0]       r_data, t_data;
    logic                   ev_q, ev_d;
    err_t                   ed_q, ed_d;
    logic [COUNT_WIDTH-1:0] sc_q, sc_d, mc_q, mc_d;

    stream_hold #(.W(ACT_W)) u_result (
        .clock(clock), .reset(reset), .in_valid(result_valid), .in_data(result_data),
        .in_ready(result_ready), .clear(join_now), .full(r_full), .data(r_data)
    );

    stream_hold #(.W(ACT_W)) u_target (
        .clock(clock), .reset(reset), .in_valid(target_valid), .in_data(target_data),
        .in_ready(target_ready), .clear(join_now), .full(t_full), .data(t_data)
    );

    always_comb begin
        join_now = r_full && t_full && (!ev_q || error_ready);
        ev_d     = join_now ? train : (error_ready ? 1'b0 : ev_q);
        ed_d     = join_now ? err_t'({8'h00, t_data} - {8'h00, r_data}) : ed_q;
        // counters stick at all-ones instead of wrapping
        sc_d     = (join_now && !(&sc_q)) ? sc_q + 1'b1 : sc_q;
        mc_d     = (join_now && (t_data != r_data) && !(&mc_q)) ? mc_q + 1'b1 : mc_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ev_q <= 1'b0;
            ed_q <= '0;
            sc_q <= '0;
            mc_q <= '0;
        end else begin
            ev_q <= ev_d;
            ed_q <= ed_d;
            sc_q <= sc_d;
            mc_q <= mc_d;
        end
    end

    assign error_valid    = ev_q;
    assign error_data     = ed_q;
    assign sample_count   = sc_q;
    assign mismatch_count = mc_q;
endmodule

// File: tb/tb_objective.sv
// tb_objective: directed checks of join, signed error, backpressure, train gating, saturation and reset.
module tb_objective;
    logic        clock = 0, reset = 1, train = 1;
    logic        result_valid = 0, target_valid = 0, error_ready = 0;
    logic [7:0]  result_data = 0, target_data = 0;
    logic        result_ready, target_ready, error_valid;
    logic [15:0] error_data, sample_count, mismatch_count;
    logic        s_rr, s_tr, s_ev;
    logic [15:0] s_ed;
    logic [1:0]  s_sc, s_mc;
    int          checks = 0, errors = 0;
    logic        ev_seen;

    always #5 clock = ~clock;

    objective dut (
        .clock(clock), .reset(reset), .train(train),
        .result_valid(result_valid), .result_data(result_data), .result_ready(result_ready),
        .target_valid(target_valid), .target_data(target_data), .target_ready(target_ready),
        .error_valid(error_valid), .error_data(error_data), .error_ready(error_ready),
        .sample_count(sample_count), .mismatch_count(mismatch_count)
    );

    objective #(.COUNT_WIDTH(2)) u_sat (
        .clock(clock), .reset(reset), .train(train),
        .result_valid(result_valid), .result_data(result_data), .result_ready(s_rr),
        .target_valid(target_valid), .target_data(target_data), .target_ready(s_tr),
        .error_valid(s_ev), .error_data(s_ed), .error_ready(error_ready),
        .sample_count(s_sc), .mismatch_count(s_mc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pair(input logic [7:0] r, input logic [7:0] t);
        result_valid = 1; result_data = r; target_valid = 1; target_data = t;
        step();
        result_valid = 0; target_valid = 0;
        step();
    endtask

    initial begin
        #2;
        chk("rst_rr", result_ready, 1);
        chk("rst_tr", target_ready, 1);
        chk("rst_ev", error_valid, 0);
        chk("rst_ed", error_data, 0);
        chk("rst_sc", sample_count, 0);
        chk("rst_mc", mismatch_count, 0);
        step();
        reset = 0;
        step();

        result_valid = 1; result_data = 8'hff; target_valid = 1; target_data = 8'hff;
        step();
        result_valid = 0; target_valid = 0;
        chk("t1_rr_low", result_ready, 0);
        chk("t1_tr_low", target_ready, 0);
        chk("t1_ev_wait", error_valid, 0);
        step();
        chk("t1_ev", error_valid, 1);
        chk("t1_ed", error_data, 16'h0000);
        chk("t1_sc", sample_count, 1);
        chk("t1_mc", mismatch_count, 0);
        chk("t1_rr_free", result_ready, 1);
        chk("t1_sat_sc", s_sc, 1);
        step();
        chk("t1_ev_hold", error_valid, 1);
        error_ready = 1;
        step();
        chk("t1_ev_drain", error_valid, 0);
        step();
        chk("t1_idle_ready", error_valid, 0);
        error_ready = 0;

        result_valid = 1; result_data = 8'h00;
        step();
        result_valid = 0;
        chk("t2_rr_low", result_ready, 0);
        step();
        step();
        chk("t2_rr_still", result_ready, 0);
        target_valid = 1; target_data = 8'hff;
        step();
        target_valid = 0;
        chk("t2_ev_wait", error_valid, 0);
        step();
        chk("t2_ev", error_valid, 1);
        chk("t2_ed", error_data, 16'h00ff);
        chk("t2_mc", mismatch_count, 1);
        error_ready = 1;
        step();
        error_ready = 0;

        pair(8'hff, 8'h00);
        chk("t3_ev", error_valid, 1);
        chk("t3_ed", error_data, 16'hff01);
        chk("t3_signed", ($signed(error_data) == -255), 1);
        chk("t3_sc", sample_count, 3);

        result_valid = 1; result_data = 8'h10; target_valid = 1; target_data = 8'h30;
        step();
        result_valid = 0; target_valid = 0;
        step();
        step();
        chk("t4_ev_held", error_valid, 1);
        chk("t4_ed_held", error_data, 16'hff01);
        chk("t4_rr_low", result_ready, 0);
        chk("t4_tr_low", target_ready, 0);
        chk("t4_sc_held", sample_count, 3);
        error_ready = 1;
        step();
        chk("t4_ev_next", error_valid, 1);
        chk("t4_ed_next", error_data, 16'h0020);
        chk("t4_sc", sample_count, 4);
        chk("t4_mc", mismatch_count, 3);
        step();
        chk("t4_ev_done", error_valid, 0);
        error_ready = 0;

        train = 0;
        ev_seen = 0;
        pair(8'd5, 8'd5); ev_seen |= error_valid;
        pair(8'd7, 8'd9); ev_seen |= error_valid;
        pair(8'd1, 8'd1); ev_seen |= error_valid;
        pair(8'd0, 8'd2); ev_seen |= error_valid;
        chk("t5_no_ev", ev_seen, 0);
        chk("t5_sc", sample_count, 8);
        chk("t5_mc", mismatch_count, 5);
        chk("t5_ed", error_data, 16'h0002);
        chk("t5_sat_sc", s_sc, 3);
        chk("t5_sat_mc", s_mc, 3);

        result_valid = 1; result_data = 8'h03;
        step();
        result_valid = 0;
        chk("t6_rr_low", result_ready, 0);
        #2 reset = 1;
        #1;
        chk("t6_rr", result_ready, 1);
        chk("t6_ev", error_valid, 0);
        chk("t6_ed", error_data, 0);
        chk("t6_sc", sample_count, 0);
        chk("t6_mc", mismatch_count, 0);
        chk("t6_sat_sc", s_sc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/objective.md
# objective

Training-side counterpart of the activation stage: consumes the activation's `result` stream plus a `target` stream, and returns the signed error on the `error` stream that feeds the activation's backward path. Joins the two input streams, computes `target - result` in 16-bit two's complement, and keeps saturating sample/mismatch counters for test and monitoring. Sits at the output end of a layer chain, closing the forward/backward loop.

## Interface
- COUNT_WIDTH, 16, width of the sample and mismatch counters
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- train  input  1  when high, joined samples produce an error transfer; when low, they are counted only
- result_valid  input  1  activation result available
- result_data  input  8  activation result, unsigned
- result_ready  output  1  result accepted when valid && ready
- target_valid  input  1  target available
- target_data  input  8  expected value, unsigned
- target_ready  output  1  target accepted when valid && ready
- error_valid  output  1  error available
- error_data  output  16  signed error, target − result
- error_ready  input  1  error consumed when valid && ready
- sample_count  output  COUNT_WIDTH  joined samples since reset, saturating
- mismatch_count  output  COUNT_WIDTH  joined samples with target ≠ result, saturating

## Operation
- Two independent holding registers (result, target), each with a full flag; `*_ready = !full`.
- Accept on valid && ready: store data, set full. Channels may arrive in any order or cycle.
- Join condition: both full && (!error_valid || error_ready).
- On join edge: error_data ← {8'h00,target} − {8'h00,result} (range −255..+255, sign-extended to 16 bits); error_valid ← train (sampled at that edge); both full flags cleared; sample_count += 1; mismatch_count += 1 if target ≠ result.
- error_valid/error_data held stable until error_ready; error_ready with error_valid low and no join leaves error_valid low.
- Same-edge error_ready and join: old error retires, new one loads; error_valid stays high.
- train low: no error transfer; counters still update; pending error (valid high) still drains normally.
- Counters saturate at all-ones; no wrap.
- No accept into a full register even if the join is happening the same edge (ready is registered-flag based).

## Timing
- Reset (async assert, sync-safe deassert): full flags 0, result_ready 1, target_ready 1, error_valid 0, error_data 0, sample_count 0, mismatch_count 0.
- Latency: last input accepted at edge N → join at edge N+1 → error_valid high after edge N+1.
- Throughput: one sample per 2 cycles with error_ready held high.
- Backpressure: error_valid high && !error_ready with both full → no join; ready stays low on both inputs until drained.
- Reset mid-operation: all held data and pending error discarded immediately.
- train toggling between accept and join: value at join edge governs.

## Structure
- Shared package: error data width (16), activation data width (8), error type as signed 16-bit typedef; reuse the package already used by the activation stage.
- Sub-module `stream_hold`: parameterised width, one-entry holding register with valid/ready input side, full flag, data out, synchronous clear on join. Instantiated twice.
- Join, subtraction, output register and counters in the top.

## Test plan
- Reset, train=1, result 8'hff and target 8'hff same cycle -> error_data 16'h0000 after one join cycle, sample_count 1, mismatch_count 0.
- train=1, result 8'h00 then target 8'hff three cycles later -> error 16'h00ff, mismatch_count 1; result_ready low while waiting.
- train=1, result 8'hff, target 8'h00 -> $signed(error_data) == −255 (16'hff01).
- error_ready held low, two samples presented -> first error held stable, second pair held in registers, both readys low; release error_ready -> second error follows next cycle, order preserved.
- train=0, 4 samples with 2 mismatches -> error_valid never asserts, sample_count 4, mismatch_count 2; assert reset mid-sample -> all outputs return to reset values within the same cycle.
